// File: rtl/mpu_sub_sequencer_if.sv
// Command, byte-stream and datapath signals between the MPU front end,
// the subtract sequencer and the external element-wise subtract unit.
interface mpu_sub_sequencer_if;
  logic         start;
  logic         busy;
  logic         done;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic [199:0] mat_a;
  logic [199:0] mat_b;
  logic [199:0] mat_result;

  // Sequencer side
  modport slave (
    input  start, in_valid, in_data, out_ready, mat_result,
    output busy, done, in_ready, out_valid, out_data, mat_a, mat_b
  );

  // Front end plus datapath side
  modport master (
    output start, in_valid, in_data, out_ready, mat_result,
    input  busy, done, in_ready, out_valid, out_data, mat_a, mat_b
  );
endinterface

// File: rtl/mpu_sub_sequencer.sv
// Loads two 5x5 int8 matrices byte by byte, presents them to the external
// subtract datapath, captures the result after a settle budget and streams it out.
module mpu_sub_sequencer #(
  parameter int N_ELEM      = 25,
  parameter int EXEC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  mpu_sub_sequencer_if.slave bus
);

  localparam int         W         = 8 * N_ELEM;
  localparam logic [4:0] LAST_ELEM = 5'(N_ELEM - 1);
  localparam logic [4:0] EXEC_LAST = 5'(EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_STORE,
    S_DONE
  } state_t;

  state_t     state_reg, state_next;
  logic [4:0] elem_cnt_reg, elem_cnt_next;
  logic [4:0] exec_cnt_reg, exec_cnt_next;

  logic [W-1:0] mat_a_reg;
  logic [W-1:0] mat_b_reg;
  logic [W-1:0] result_reg;

  logic busy_int, done_int, in_ready_int, out_valid_int, capture;
  logic in_fire, out_fire, last_elem;
  logic load_a_fire, load_b_fire;

  logic [N_ELEM-1:0] lane_sel;
  logic [7:0]        result_lane [N_ELEM];

  assign in_fire     = bus.in_valid && in_ready_int;
  assign out_fire    = out_valid_int && bus.out_ready;
  assign last_elem   = (elem_cnt_reg == LAST_ELEM);
  assign load_a_fire = in_fire && (state_reg == S_LOAD_A);
  assign load_b_fire = in_fire && (state_reg == S_LOAD_B);

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      elem_cnt_reg <= '0;
      exec_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      elem_cnt_reg <= elem_cnt_next;
      exec_cnt_reg <= exec_cnt_next;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_next    = state_reg;
    elem_cnt_next = elem_cnt_reg;
    exec_cnt_next = exec_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          state_next    = S_LOAD_A;
          elem_cnt_next = '0;
        end
      end
      S_LOAD_A: begin
        if (in_fire) begin
          if (last_elem) begin
            state_next    = S_LOAD_B;
            elem_cnt_next = '0;
          end else begin
            elem_cnt_next = elem_cnt_reg + 5'd1;
          end
        end
      end
      S_LOAD_B: begin
        if (in_fire) begin
          if (last_elem) begin
            state_next    = S_EXEC;
            elem_cnt_next = '0;
            exec_cnt_next = '0;
          end else begin
            elem_cnt_next = elem_cnt_reg + 5'd1;
          end
        end
      end
      S_EXEC: begin
        if (exec_cnt_reg == EXEC_LAST) begin
          state_next    = S_STORE;
          elem_cnt_next = '0;
        end else begin
          exec_cnt_next = exec_cnt_reg + 5'd1;
        end
      end
      S_STORE: begin
        if (out_fire) begin
          if (last_elem) begin
            state_next    = S_DONE;
            elem_cnt_next = '0;
          end else begin
            elem_cnt_next = elem_cnt_reg + 5'd1;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next    = S_IDLE;
        elem_cnt_next = '0;
        exec_cnt_next = '0;
      end
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy_int      = 1'b0;
    done_int      = 1'b0;
    in_ready_int  = 1'b0;
    out_valid_int = 1'b0;
    capture       = 1'b0;
    case (state_reg)
      S_IDLE:   busy_int = 1'b0;
      S_LOAD_A: begin busy_int = 1'b1; in_ready_int = 1'b1; end
      S_LOAD_B: begin busy_int = 1'b1; in_ready_int = 1'b1; end
      S_EXEC: begin
        busy_int = 1'b1;
        capture  = (exec_cnt_reg == EXEC_LAST);
      end
      S_STORE:  begin busy_int = 1'b1; out_valid_int = 1'b1; end
      S_DONE:   begin busy_int = 1'b1; done_int = 1'b1; end
      default:  busy_int = 1'b0;
    endcase
  end

  // One-hot lane select from the element counter, and the result lane view
  for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_lane
    assign lane_sel[gi]    = (elem_cnt_reg == 5'(gi));
    assign result_lane[gi] = result_reg[8*gi +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mat_a_reg  <= '0;
      mat_b_reg  <= '0;
      result_reg <= '0;
    end else begin
      for (int i = 0; i < N_ELEM; i++) begin
        if (load_a_fire && lane_sel[i]) mat_a_reg[8*i +: 8] <= bus.in_data;
        if (load_b_fire && lane_sel[i]) mat_b_reg[8*i +: 8] <= bus.in_data;
      end
      if (capture) result_reg <= bus.mat_result;
    end
  end

  assign bus.busy      = busy_int;
  assign bus.done      = done_int;
  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.out_data  = out_valid_int ? result_lane[elem_cnt_reg] : 8'd0;
  assign bus.mat_a     = mat_a_reg;
  assign bus.mat_b     = mat_b_reg;

endmodule

// File: tb/tb_mpu_sub_sequencer.sv
// Self-checking bench: per-run vector tables feed a scoreboard queue that is
// drained against the sequencer's output stream.
module tb_mpu_sub_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  mpu_sub_sequencer_if bus ();

  mpu_sub_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the external subtract unit
  for (genvar gi = 0; gi < 25; gi++) begin : g_sub
    assign bus.mat_result[8*gi +: 8] = bus.mat_a[8*gi +: 8] - bus.mat_b[8*gi +: 8];
  end

  always @(negedge clk) begin
    if (!reset) begin
      assert (dut.elem_cnt_reg <= 5'd24);
      assert (dut.exec_cnt_reg <= 5'd14);
    end
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs [25];
  logic [7:0] sb_q [$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         t_start = 0;
  int         elapsed = 0;

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [199:0] flat_a();
    logic [199:0] f;
    for (int k = 0; k < 25; k++) f[8*k +: 8] = vecs[k].a;
    return f;
  endfunction

  function automatic logic [199:0] flat_b();
    logic [199:0] f;
    for (int k = 0; k < 25; k++) f[8*k +: 8] = vecs[k].b;
    return f;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 200'(bus.busy), 200'd0);
    check({tag, "_done"}, 200'(bus.done), 200'd0);
    check({tag, "_in_ready"}, 200'(bus.in_ready), 200'd0);
    check({tag, "_out_valid"}, 200'(bus.out_valid), 200'd0);
    check({tag, "_out_data"}, 200'(bus.out_data), 200'd0);
    check({tag, "_mat_a"}, bus.mat_a, 200'd0);
    check({tag, "_mat_b"}, bus.mat_b, 200'd0);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit gaps, input bit pulse_start);
    bit accepted = 1'b0;
    int guard = 0;
    while (!accepted) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.start    = pulse_start;
        accepted     = bus.in_ready;
      end
      @(posedge clk);
      guard++;
      if (guard > 60) begin
        check("in_ready_timeout", 200'(accepted), 200'd1);
        accepted = 1'b1;
      end
    end
  endtask

  task automatic start_op();
    @(negedge clk);
    bus.start = 1'b1;
    t_start   = cyc;
  endtask

  // Returns early (after the transfer edge of B[abort_at-1]) when abort_at >= 0
  task automatic load_mats(input bit gaps, input bit stray_start, input int abort_at);
    for (int k = 0; k < 25; k++) send_byte(vecs[k].a, gaps, 1'b0);
    for (int k = 0; k < 25; k++) begin
      if (k == abort_at) return;
      send_byte(vecs[k].b, gaps, stray_start && (k == 7));
      sb_q.push_back(vecs[k].exp);
    end
  endtask

  task automatic drain(input bit toggle_ready, input bit stray_start);
    int lat = 1;
    int got = 0;
    int guard = 0;
    bit stalled = 1'b0;
    logic [7:0] held = 8'd0;
    logic [7:0] exp;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("first_out_latency", 200'(lat), 200'd2);
    while (got < 25 && guard < 300) begin
      guard++;
      check("out_valid_in_store", 200'(bus.out_valid), 200'd1);
      if (stalled) check("held_while_stalled", 200'(bus.out_data), 200'(held));
      if (toggle_ready) bus.out_ready = ~bus.out_ready;
      if (bus.out_ready) begin
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        check($sformatf("out_data[%0d]", got), 200'(bus.out_data), 200'(exp));
        got++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = bus.out_data;
      end
      @(negedge clk);
    end
    check("output_count", 200'(got), 200'd25);
    bus.out_ready = 1'b1;
    check("done_pulse", 200'(bus.done), 200'd1);
    check("busy_in_done", 200'(bus.busy), 200'd1);
    check("out_valid_after_store", 200'(bus.out_valid), 200'd0);
    if (stray_start) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    elapsed   = cyc - t_start;
    check("done_single_cycle", 200'(bus.done), 200'd0);
    check("idle_after_done", 200'(bus.busy), 200'd0);
    @(negedge clk);
    check("no_restart_busy", 200'(bus.busy), 200'd0);
    check("no_restart_in_ready", 200'(bus.in_ready), 200'd0);
    check("no_extra_done", 200'(bus.done), 200'd0);
    check("scoreboard_empty", 200'(sb_q.size()), 200'd0);
  endtask

  task automatic fill_random();
    for (int k = 0; k < 25; k++) begin
      vecs[k].a   = 8'($urandom);
      vecs[k].b   = 8'($urandom);
      vecs[k].exp = vecs[k].a - vecs[k].b;
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.out_ready = 1'b1;

    // Power-on reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("por");

    // Nominal run: A[k]=k+1, B[k]=25-k, result 2k-24
    for (int k = 0; k < 25; k++) begin
      vecs[k].a   = 8'(k + 1);
      vecs[k].b   = 8'(25 - k);
      vecs[k].exp = 8'(2 * k - 24);
    end
    start_op();
    load_mats(1'b0, 1'b0, -1);
    drain(1'b0, 1'b0);
    check("start_to_idle_cycles", 200'(elapsed), 200'd78);
    check("mat_a_held", bus.mat_a, flat_a());
    check("mat_b_held", bus.mat_b, flat_b());

    // Wrap-around extremes
    for (int k = 0; k < 25; k++) begin
      vecs[k].a   = 8'd0;
      vecs[k].b   = 8'd0;
      vecs[k].exp = 8'd0;
    end
    vecs[0].a  = 8'h80; vecs[0].b  = 8'h01; vecs[0].exp  = 8'h7F;
    vecs[24].a = 8'h7F; vecs[24].b = 8'hFF; vecs[24].exp = 8'h80;
    start_op();
    load_mats(1'b0, 1'b0, -1);
    drain(1'b0, 1'b0);

    // Output backpressure with the nominal data
    for (int k = 0; k < 25; k++) begin
      vecs[k].a   = 8'(k + 1);
      vecs[k].b   = 8'(25 - k);
      vecs[k].exp = 8'(2 * k - 24);
    end
    start_op();
    load_mats(1'b0, 1'b0, -1);
    drain(1'b1, 1'b0);

    // Input gaps plus stray start in LOAD_B and DONE
    fill_random();
    start_op();
    load_mats(1'b1, 1'b1, -1);
    drain(1'b0, 1'b1);
    check("gap_run_mat_a", bus.mat_a, flat_a());

    // Reset in LOAD_B at k=10 aborts the run
    fill_random();
    start_op();
    load_mats(1'b0, 1'b0, 10);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_reset_state("mid_load_b");
    sb_q.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_output_after_abort", 200'(bus.out_valid | bus.busy), 200'd0);
    end

    // Fresh run after the abort
    fill_random();
    start_op();
    load_mats(1'b0, 1'b0, -1);
    drain(1'b0, 1'b0);
    check("fresh_mat_b", bus.mat_b, flat_b());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound so the bench always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mpu_sub_sequencer.md
Name: mpu_sub_sequencer

Overview:
Sequencer that feeds the MPU's combinational 5x5 int8 element-wise subtract datapath. It loads matrix A and then matrix B as 25-byte streams into internal flattened registers, and drives those registers onto the datapath. It waits a fixed settle time, captures the 200-bit result, and streams it back out byte by byte. The block sits between the MPU command/byte-stream interface and the subtract unit; the subtract unit itself is instantiated outside this block.

Parameters:
N_ELEM, 25, number of matrix elements (5x5); fixed for this MPU; sets counter range.
EXEC_CYCLES, 1, clock cycles spent in EXEC before the result is captured (datapath settle budget); legal range 1..15.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin an operation; sampled only in IDLE
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the last result byte is accepted
in_valid  input  1  input byte valid
in_ready  output  1  sequencer can accept an input byte
in_data  input  8  signed element; A elements first, then B elements, index k=0..24
out_valid  output  1  result byte valid
out_ready  input  1  downstream accepts the result byte
out_data  output  8  signed result element, index k=0..24
mat_a  output  200  flattened A to the datapath; element k at bits [8k+7:8k]
mat_b  output  200  flattened B to the datapath; same layout
mat_result  input  200  flattened A-B from the datapath; same layout

Behaviour:
- Element index k = row*5 + col. Element k occupies byte lane [8k+7:8k] on all 200-bit buses.
- Reset (synchronous, active-high) has priority over every other event:
  - State goes to IDLE; element counter and exec counter clear to 0.
  - mat_a, mat_b and the result register clear to 0.
  - busy=0, done=0, in_ready=0, out_valid=0, out_data=0.
  - Reset in any state aborts the operation; partially loaded data is discarded.
- States: IDLE -> LOAD_A -> LOAD_B -> EXEC -> STORE -> DONE -> IDLE.
- IDLE:
  - start=1 -> LOAD_A, counter=0.
  - in_valid is ignored.
- LOAD_A:
  - in_ready=1.
  - On in_valid&&in_ready: mat_a lane k <= in_data, then k++.
  - Transfer at k=24 -> LOAD_B with k=0.
  - Gaps in in_valid stall the load without any limit.
- LOAD_B:
  - Same as LOAD_A, writing into mat_b.
  - Transfer at k=24 -> EXEC; exec counter=0.
  - in_ready drops in the cycle after the 25th B transfer.
- EXEC:
  - in_ready=0.
  - Exec counter increments each cycle.
  - When the counter reaches EXEC_CYCLES-1: result register <= mat_result, k=0, -> STORE.
  - Default latency from the last B transfer to the first out_valid is 2 cycles.
- STORE:
  - out_valid=1; out_data = result register lane k.
  - On out_valid&&out_ready: k++.
  - While out_ready=0, out_data and out_valid hold stable.
  - Transfer at k=24 -> DONE.
- DONE: done=1 for exactly one cycle, busy=1, then -> IDLE.
- start while busy (any non-IDLE state, including DONE): ignored, no effect.
- Arithmetic: performed by the datapath as 8-bit two's-complement, wrapping modulo 256, no saturation. The sequencer passes bytes through unmodified.
- mat_a and mat_b hold their values after the operation until the next load overwrites them lane by lane.
- Counters are 5 bits wide and never exceed 24. No wrap-around is reachable; the bench checks this with an assertion.

Test Plan:
- Reset check: assert reset for 2 cycles mid-stream -> busy=0, done=0, in_ready=0, out_valid=0, out_data=0, mat_a=mat_b=0 on the following cycle.
- Nominal run: A[k]=k+1 and B[k]=25-k, streamed back-to-back with out_ready=1 -> 25 outputs with out_data[k]=2k-24 (-24, -22, ..., 0 at k=12, ..., 24), done pulses once, and 50+2+25+1 cycles elapse from start to IDLE.
- Wrap case: A[0]=-128 and B[0]=1; A[24]=127 and B[24]=-1; all other elements 0 -> out_data[0]=127 (0x7F), out_data[24]=-128 (0x80), all others 0.
- Output backpressure: toggle out_ready 0/1 every cycle in STORE -> every byte is held stable while stalled, none are dropped or duplicated, and the sequence matches the nominal run.
- Input gaps and stray start: random in_valid gaps, with start pulsed during LOAD_B and during DONE -> operation completes exactly once with correct results; no restart occurs and no extra done pulse appears.
- Reset mid-LOAD_B at k=10, then a fresh full run -> the first run produces no output; the second run's results are correct and unaffected by stale lanes.
